// File: rtl/multicycle_control_if.sv
// Instruction/data memory handshake between the sequencer (master) and memory (slave).
interface multicycle_control_if #(
   parameter int NBITS = 8
);
   logic [NBITS-1:0] IAddr;
   logic             IReq;
   logic             IReady;
   logic [31:0]      Instr;
   logic             MemRead;
   logic             MemWrite;
   logic             MemReady;

   modport master (
      output IAddr, IReq, MemRead, MemWrite,
      input  IReady, Instr, MemReady
   );

   modport slave (
      input  IAddr, IReq, MemRead, MemWrite,
      output IReady, Instr, MemReady
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit RISC-V teaching core.
// Owns the PC and IR; all control outputs are Moore-decoded from state and IR.
module multicycle_control #(
   parameter int NBITS      = 8,
   parameter int NREGS      = 32,
   parameter int WIDTH_ALUF = 4,
   localparam int RW        = $clog2(NREGS)
) (
   input  logic                  clock,
   input  logic                  reset,
   multicycle_control_if.master  bus,
   output logic [RW-1:0]         RS1,
   output logic [RW-1:0]         RS2,
   output logic [RW-1:0]         RD,
   output logic [NBITS-1:0]      IMM,
   output logic [WIDTH_ALUF-1:0] ALUControl,
   output logic                  ALUSrc,
   output logic                  MemtoReg,
   output logic                  RegWrite,
   output logic                  link,
   output logic [NBITS-1:0]      pclink,
   input  logic [NBITS-1:0]      PCReg,
   output logic                  Illegal,
   output logic [2:0]            State
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } stateType;

   typedef enum logic [3:0] {
      OP_ADDI, OP_SRLI, OP_ADD, OP_SRL, OP_LW, OP_SW, OP_JAL, OP_JALR, OP_BAD
   } opType;

   localparam logic [WIDTH_ALUF-1:0] ALU_ADD = WIDTH_ALUF'(4'b0000);
   localparam logic [WIDTH_ALUF-1:0] ALU_SRL = WIDTH_ALUF'(4'b0101);

   stateType         state;
   opType            op;
   logic [31:0]      ir;
   logic [NBITS-1:0] pc;
   logic             illegalFlag;
   logic             running;
   logic [31:0]      immFull;
   logic [31-NBITS:0] unusedImm;

   // Classify the latched instruction; anything outside the supported subset is OP_BAD.
   always_comb begin
      op = OP_BAD;
      case (ir[6:0])
         7'b0010011: begin
            if (ir[14:12] == 3'b000)
               op = OP_ADDI;
            else if (ir[14:12] == 3'b101 && ir[31:25] == 7'b0)
               op = OP_SRLI;
         end
         7'b0110011: begin
            if (ir[31:25] == 7'b0 && ir[14:12] == 3'b000)
               op = OP_ADD;
            else if (ir[31:25] == 7'b0 && ir[14:12] == 3'b101)
               op = OP_SRL;
         end
         7'b0000011: if (ir[14:12] == 3'b010) op = OP_LW;
         7'b0100011: if (ir[14:12] == 3'b010) op = OP_SW;
         7'b1101111: op = OP_JAL;
         7'b1100111: if (ir[14:12] == 3'b000) op = OP_JALR;
         default:    op = OP_BAD;
      endcase
   end

   // Immediate is built full width and then truncated to the datapath width.
   always_comb begin
      immFull = 32'b0;
      case (op)
         OP_ADDI, OP_LW, OP_JALR: immFull = {{20{ir[31]}}, ir[31:20]};
         OP_SRLI:                 immFull = {27'b0, ir[24:20]};
         OP_SW:                   immFull = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         OP_JAL:                  immFull = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default:                 immFull = 32'b0;
      endcase
   end

   assign IMM       = immFull[NBITS-1:0];
   assign unusedImm = immFull[31:NBITS];
   assign RS1       = ir[15 +: RW];
   assign RS2       = ir[20 +: RW];
   assign RD        = ir[7 +: RW];
   assign bus.IAddr = pc;
   assign pclink    = pc + NBITS'(4);
   assign Illegal   = illegalFlag;
   assign State     = state;

   // Moore control decode; running keeps IReq low until the first edge after reset release.
   always_comb begin
      bus.IReq     = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      ALUControl   = ALU_ADD;
      ALUSrc       = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      link         = 1'b0;
      case (state)
         FETCH: bus.IReq = running;
         EXEC: begin
            case (op)
               OP_ADDI: begin RegWrite = 1'b1; ALUSrc = 1'b1; end
               OP_SRLI: begin RegWrite = 1'b1; ALUSrc = 1'b1; ALUControl = ALU_SRL; end
               OP_ADD:  RegWrite = 1'b1;
               OP_SRL:  begin RegWrite = 1'b1; ALUControl = ALU_SRL; end
               OP_LW, OP_SW: ALUSrc = 1'b1;
               OP_JAL, OP_JALR: begin link = 1'b1; RegWrite = 1'b1; end
               default: ;
            endcase
         end
         MEM: begin
            ALUSrc       = 1'b1;
            bus.MemRead  = (op == OP_LW);
            bus.MemWrite = (op == OP_SW);
         end
         WB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            ALUSrc   = 1'b1;
         end
         default: ;
      endcase
   end

   // Sequencer: the PC only moves on the edge that retires an instruction.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= FETCH;
         pc          <= '0;
         ir          <= '0;
         illegalFlag <= 1'b0;
         running     <= 1'b0;
      end else begin
         running <= 1'b1;
         case (state)
            FETCH: begin
               if (running && bus.IReady) begin
                  ir    <= bus.Instr;
                  state <= DECODE;
               end
            end
            DECODE: begin
               if (op == OP_BAD) begin
                  illegalFlag <= 1'b1;
                  state       <= HALT;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               case (op)
                  OP_LW, OP_SW: state <= MEM;
                  OP_JAL: begin
                     pc    <= pc + IMM;
                     state <= FETCH;
                  end
                  OP_JALR: begin
                     pc    <= (PCReg + IMM) & ~NBITS'(1);
                     state <= FETCH;
                  end
                  default: begin
                     pc    <= pc + NBITS'(4);
                     state <= FETCH;
                  end
               endcase
            end
            MEM: begin
               if (bus.MemReady) begin
                  if (op == OP_SW) begin
                     pc    <= pc + NBITS'(4);
                     state <= FETCH;
                  end else begin
                     state <= WB;
                  end
               end
            end
            WB: begin
               pc    <= pc + NBITS'(4);
               state <= FETCH;
            end
            HALT:    state <= HALT;
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: ALU ops, LW wait states, jumps with PC wrap,
// illegal-opcode halt and reset abort mid-MEM, against hand-computed values.
module tb_multicycle_control;

   logic        clock;
   logic        reset;
   logic [4:0]  RS1, RS2, RD;
   logic [7:0]  IMM;
   logic [3:0]  ALUControl;
   logic        ALUSrc, MemtoReg, RegWrite, link;
   logic [7:0]  pclink;
   logic [7:0]  PCReg;
   logic        Illegal;
   logic [2:0]  State;
   logic [31:0] imem [64];
   int          checkCount;
   int          errorCount;
   int          cycleCount;
   int          startCycle;

   multicycle_control_if #(.NBITS(8)) bus ();

   multicycle_control #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .RS1        (RS1),
      .RS2        (RS2),
      .RD         (RD),
      .IMM        (IMM),
      .ALUControl (ALUControl),
      .ALUSrc     (ALUSrc),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .link       (link),
      .pclink     (pclink),
      .PCReg      (PCReg),
      .Illegal    (Illegal),
      .State      (State)
   );

   assign bus.Instr = imem[bus.IAddr[7:2]];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle 1 time unit past the edge before sampling.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
      cycleCount++;
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      cycleCount = 0;
      reset = 1'b0;
      bus.IReady = 1'b0;
      bus.MemReady = 1'b0;
      PCReg = 8'd0;
      for (int i = 0; i < 64; i++) imem[i] = 32'h0;
      imem[0] = 32'h00500093;   // ADDI x1,x0,5
      imem[1] = 32'h0010D113;   // SRLI x2,x1,1
      imem[2] = 32'h004151B3;   // SRL  x3,x2,x4
      imem[3] = 32'h00802283;   // LW   x5,8(x0)
      imem[4] = 32'h00000063;   // BEQ  (illegal here)

      applyStimulus();
      applyStimulus();
      checkOutput("rstIReq", bus.IReq, 0);
      checkOutput("rstIAddr", bus.IAddr, 0);
      checkOutput("rstPclink", pclink, 8'd4);
      checkOutput("rstState", State, 0);
      checkOutput("rstIllegal", Illegal, 0);
      checkOutput("rstRegWrite", RegWrite, 0);
      checkOutput("rstMemRead", bus.MemRead, 0);
      reset = 1'b1;
      bus.IReady = 1'b1;
      checkOutput("releaseIReq", bus.IReq, 0);

      // ADDI x1,x0,5
      applyStimulus();
      checkOutput("addiFetchIReq", bus.IReq, 1);
      checkOutput("addiFetchIAddr", bus.IAddr, 0);
      applyStimulus();
      checkOutput("addiDecodeState", State, 1);
      checkOutput("addiDecodeRegWrite", RegWrite, 0);
      applyStimulus();
      checkOutput("addiExecState", State, 2);
      checkOutput("addiRegWrite", RegWrite, 1);
      checkOutput("addiALUSrc", ALUSrc, 1);
      checkOutput("addiIMM", IMM, 8'd5);
      checkOutput("addiRD", RD, 5'd1);
      checkOutput("addiALUControl", ALUControl, 4'b0000);
      checkOutput("addiLink", link, 0);
      applyStimulus();
      checkOutput("addiNextIAddr", bus.IAddr, 8'd4);
      checkOutput("addiNextState", State, 0);

      // SRLI x2,x1,1
      applyStimulus();
      applyStimulus();
      checkOutput("srliALUControl", ALUControl, 4'b0101);
      checkOutput("srliALUSrc", ALUSrc, 1);
      checkOutput("srliIMM", IMM, 8'd1);
      checkOutput("srliRS1", RS1, 5'd1);
      checkOutput("srliRD", RD, 5'd2);
      checkOutput("srliRegWrite", RegWrite, 1);
      applyStimulus();
      checkOutput("srliNextIAddr", bus.IAddr, 8'd8);

      // SRL x3,x2,x4; MemReady pulsed here must be ignored
      applyStimulus();
      applyStimulus();
      checkOutput("srlALUControl", ALUControl, 4'b0101);
      checkOutput("srlALUSrc", ALUSrc, 0);
      checkOutput("srlRS1", RS1, 5'd2);
      checkOutput("srlRS2", RS2, 5'd4);
      checkOutput("srlRD", RD, 5'd3);
      checkOutput("srlRegWrite", RegWrite, 1);
      bus.MemReady = 1'b1;
      applyStimulus();
      bus.MemReady = 1'b0;
      checkOutput("srlNextIAddr", bus.IAddr, 8'd12);
      checkOutput("srlNextState", State, 0);

      // LW x5,8(x0) with MemReady on the third MEM cycle
      startCycle = cycleCount;
      applyStimulus();
      applyStimulus();
      checkOutput("lwExecALUSrc", ALUSrc, 1);
      checkOutput("lwExecMemRead", bus.MemRead, 0);
      checkOutput("lwExecRegWrite", RegWrite, 0);
      checkOutput("lwIMM", IMM, 8'd8);
      checkOutput("lwRD", RD, 5'd5);
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("lwMemRead", bus.MemRead, 1);
         checkOutput("lwMemState", State, 3);
         checkOutput("lwMemALUSrc", ALUSrc, 1);
         checkOutput("lwMemRegWrite", RegWrite, 0);
      end
      bus.MemReady = 1'b1;
      applyStimulus();
      bus.MemReady = 1'b0;
      checkOutput("lwWbState", State, 4);
      checkOutput("lwWbMemtoReg", MemtoReg, 1);
      checkOutput("lwWbRegWrite", RegWrite, 1);
      checkOutput("lwWbALUSrc", ALUSrc, 1);
      checkOutput("lwWbMemRead", bus.MemRead, 0);
      checkOutput("lwWbIAddr", bus.IAddr, 8'd12);
      applyStimulus();
      checkOutput("lwNextIAddr", bus.IAddr, 8'd16);
      checkOutput("lwLatency", cycleCount - startCycle, 7);

      // Unsupported BEQ halts until reset
      applyStimulus();
      checkOutput("beqDecodeState", State, 1);
      applyStimulus();
      checkOutput("haltState", State, 5);
      checkOutput("haltIllegal", Illegal, 1);
      checkOutput("haltIReq", bus.IReq, 0);
      for (int i = 0; i < 5; i++) applyStimulus();
      checkOutput("haltStillIReq", bus.IReq, 0);
      checkOutput("haltStillIllegal", Illegal, 1);
      checkOutput("haltStillIAddr", bus.IAddr, 8'd16);

      for (int i = 0; i < 64; i++) imem[i] = 32'h0;
      imem[0] = 32'h0080006F;   // JAL  x0,+8
      imem[2] = 32'h0FC000EF;   // JAL  x1,+252
      imem[1] = 32'h00108067;   // JALR x0,x1,1
      imem[3] = 32'h00502223;   // SW   x5,4(x0)
      reset = 1'b0;
      applyStimulus();
      reset = 1'b1;
      checkOutput("clrIllegal", Illegal, 0);
      checkOutput("clrIAddr", bus.IAddr, 0);
      checkOutput("clrState", State, 0);
      applyStimulus();
      checkOutput("clrIReq", bus.IReq, 1);

      // JAL x0,+8 from PC 0
      applyStimulus();
      applyStimulus();
      checkOutput("jal8Link", link, 1);
      checkOutput("jal8RegWrite", RegWrite, 1);
      checkOutput("jal8IMM", IMM, 8'd8);
      applyStimulus();
      checkOutput("jal8NextIAddr", bus.IAddr, 8'd8);

      // JAL x1,+252 from PC 8 wraps to 4
      applyStimulus();
      applyStimulus();
      checkOutput("jalLink", link, 1);
      checkOutput("jalRegWrite", RegWrite, 1);
      checkOutput("jalPclink", pclink, 8'd12);
      checkOutput("jalIMM", IMM, 8'hFC);
      checkOutput("jalRD", RD, 5'd1);
      PCReg = 8'd12;
      applyStimulus();
      checkOutput("jalWrapIAddr", bus.IAddr, 8'd4);

      // JALR x0,x1,1 with PCReg=12 clears bit 0
      applyStimulus();
      applyStimulus();
      checkOutput("jalrLink", link, 1);
      checkOutput("jalrIMM", IMM, 8'd1);
      checkOutput("jalrRS1", RS1, 5'd1);
      checkOutput("jalrALUSrc", ALUSrc, 0);
      applyStimulus();
      checkOutput("jalrIAddr", bus.IAddr, 8'd12);

      // SW x5,4(x0) aborted by reset while MemWrite is pending
      applyStimulus();
      applyStimulus();
      checkOutput("swExecALUSrc", ALUSrc, 1);
      checkOutput("swIMM", IMM, 8'd4);
      checkOutput("swRS2", RS2, 5'd5);
      checkOutput("swExecMemWrite", bus.MemWrite, 0);
      applyStimulus();
      checkOutput("swMemWrite", bus.MemWrite, 1);
      checkOutput("swMemState", State, 3);
      applyStimulus();
      checkOutput("swMemWriteHeld", bus.MemWrite, 1);
      checkOutput("swMemRegWrite", RegWrite, 0);
      reset = 1'b0;
      applyStimulus();
      checkOutput("abortMemWrite", bus.MemWrite, 0);
      checkOutput("abortIAddr", bus.IAddr, 0);
      checkOutput("abortState", State, 0);
      checkOutput("abortRegWrite", RegWrite, 0);
      reset = 1'b1;
      applyStimulus();
      checkOutput("restartIReq", bus.IReq, 1);

      // Rerun the jumps, then SW with zero wait states takes 4 cycles
      for (int i = 0; i < 9; i++) applyStimulus();
      checkOutput("rerunIAddr", bus.IAddr, 8'd12);
      checkOutput("rerunState", State, 0);
      bus.MemReady = 1'b1;
      startCycle = cycleCount;
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("swFastState", State, 3);
      checkOutput("swFastIAddr", bus.IAddr, 8'd12);
      applyStimulus();
      checkOutput("swDoneIAddr", bus.IAddr, 8'd16);
      checkOutput("swDoneState", State, 0);
      checkOutput("swLatency", cycleCount - startCycle, 4);
      bus.MemReady = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
